// File: rtl/wm8731_cfg_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: FSM states, LUT entry layout
// and the early-terminator marker.
package wm8731_cfg_pkg;

   typedef enum logic [2:0] {
      StWaitInit,
      StCheck,
      StReq,
      StWaitAck,
      StGap,
      StDone,
      StFail
   } state_e;

   localparam int unsigned LutSizeDefault = 10;

   // LUT entry layout: {dev_addr[31:24], reg_addr[23:8], data[7:0]}
   localparam int unsigned DevAddrLsb = 24;
   localparam int unsigned RegAddrLsb = 8;
   localparam int unsigned DataLsb    = 0;

   localparam logic [31:0] LutTerminator = 32'hFFFF_FFFF;

   function automatic logic [7:0] lut_dev_addr(input logic [31:0] entry);
      return entry[DevAddrLsb +: 8];
   endfunction

   function automatic logic [15:0] lut_reg_addr(input logic [31:0] entry);
      return entry[RegAddrLsb +: 16];
   endfunction

   function automatic logic [7:0] lut_wr_data(input logic [31:0] entry);
      return entry[DataLsb +: 8];
   endfunction

endpackage

// File: rtl/i2c_config_seq_if.sv
// Write-request bus between the configuration sequencer (master) and the I2C write engine
// (slave).
interface i2c_config_seq_if;

   logic        i2c_write_req;
   logic        i2c_write_req_ack;
   logic        i2c_error;
   logic [7:0]  i2c_slave_dev_addr;
   logic [15:0] i2c_register_addr;
   logic [7:0]  i2c_data;
   logic        i2c_addr_2byte;

   modport master (
      output i2c_write_req,
      output i2c_slave_dev_addr,
      output i2c_register_addr,
      output i2c_data,
      output i2c_addr_2byte,
      input  i2c_write_req_ack,
      input  i2c_error
   );

   modport slave (
      input  i2c_write_req,
      input  i2c_slave_dev_addr,
      input  i2c_register_addr,
      input  i2c_data,
      input  i2c_addr_2byte,
      output i2c_write_req_ack,
      output i2c_error
   );

endinterface

// File: rtl/i2c_config_seq.sv
// Walks the WM8731 register LUT after a power-up delay, issuing one I2C write per entry with
// bounded retries on NACK; a start pulse re-runs the table.
module i2c_config_seq
   import wm8731_cfg_pkg::*;
#(
   parameter int unsigned LUT_SIZE   = LutSizeDefault,
   parameter int unsigned INIT_DELAY = 50000,
   parameter int unsigned RETRY_MAX  = 3,
   parameter bit          ADDR_2BYTE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [9:0]       lut_index,
   input  logic [31:0]      lut_data,
   i2c_config_seq_if.master bus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [9:0]       fail_index
);

   localparam logic [31:0] InitLast  = 32'(INIT_DELAY - 1);
   localparam logic [9:0]  LutLast   = 10'(LUT_SIZE - 1);
   localparam logic [9:0]  LutSizeW  = 10'(LUT_SIZE);
   localparam logic [7:0]  RetryMaxW = 8'(RETRY_MAX);

   state_e      r_state, w_state_nxt;
   logic [31:0] r_delay_cnt, w_delay_cnt_nxt;
   logic [9:0]  r_lut_index, w_lut_index_nxt;
   logic [7:0]  r_retry_cnt, w_retry_cnt_nxt;
   logic        r_req, w_req_nxt;
   logic [7:0]  r_dev, w_dev_nxt;
   logic [15:0] r_reg, w_reg_nxt;
   logic [7:0]  r_data, w_data_nxt;
   logic        r_done, w_done_nxt;
   logic        r_error, w_error_nxt;
   logic        r_busy, w_busy_nxt;
   logic [9:0]  r_fail_index, w_fail_index_nxt;
   logic        r_pending, w_pending_nxt;
   logic        w_in_end;
   logic        w_restart;

   assign w_in_end  = (r_state == StDone) || (r_state == StFail);
   assign w_restart = w_in_end && (start || r_pending);

   always_comb begin
      w_state_nxt      = r_state;
      w_delay_cnt_nxt  = r_delay_cnt;
      w_lut_index_nxt  = r_lut_index;
      w_retry_cnt_nxt  = r_retry_cnt;
      w_req_nxt        = r_req;
      w_dev_nxt        = r_dev;
      w_reg_nxt        = r_reg;
      w_data_nxt       = r_data;
      w_fail_index_nxt = r_fail_index;
      // Starts arriving mid-sequence collapse into a single deferred restart.
      w_pending_nxt    = r_pending || (start && !w_in_end);

      unique case (r_state)
         StWaitInit: begin
            if (r_delay_cnt == InitLast) begin
               w_delay_cnt_nxt = '0;
               w_state_nxt     = StCheck;
            end else begin
               w_delay_cnt_nxt = r_delay_cnt + 32'd1;
            end
         end
         StCheck: begin
            if ((lut_data == LutTerminator) || (r_lut_index >= LutSizeW)) begin
               w_state_nxt = StDone;
            end else begin
               w_dev_nxt       = lut_dev_addr(lut_data);
               w_reg_nxt       = lut_reg_addr(lut_data);
               w_data_nxt      = lut_wr_data(lut_data);
               w_retry_cnt_nxt = '0;
               w_state_nxt     = StReq;
            end
         end
         StReq: begin
            w_req_nxt   = 1'b1;
            w_state_nxt = StWaitAck;
         end
         StWaitAck: begin
            if (bus.i2c_write_req_ack) begin
               w_req_nxt = 1'b0;
               if (!bus.i2c_error) begin
                  if (r_lut_index == LutLast) begin
                     w_state_nxt = StDone;
                  end else begin
                     w_lut_index_nxt = r_lut_index + 10'd1;
                     w_state_nxt     = StCheck;
                  end
               end else begin
                  w_retry_cnt_nxt = r_retry_cnt + 8'd1;
                  if ((r_retry_cnt + 8'd1) < RetryMaxW) begin
                     w_state_nxt = StGap;
                  end else begin
                     w_fail_index_nxt = r_lut_index;
                     w_state_nxt      = StFail;
                  end
               end
            end
         end
         StGap: begin
            w_state_nxt = StReq;
         end
         StDone, StFail: begin
            if (w_restart) begin
               w_pending_nxt    = 1'b0;
               w_lut_index_nxt  = '0;
               w_fail_index_nxt = '0;
               w_state_nxt      = StCheck;
            end
         end
         default: begin
            w_state_nxt = StWaitInit;
         end
      endcase

      // Status is registered from the next state so it aligns with the state it reports.
      w_done_nxt  = (w_state_nxt == StDone);
      w_error_nxt = (w_state_nxt == StFail);
      w_busy_nxt  = !((w_state_nxt == StDone) || (w_state_nxt == StFail));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StWaitInit;
         r_delay_cnt  <= '0;
         r_lut_index  <= '0;
         r_retry_cnt  <= '0;
         r_req        <= 1'b0;
         r_dev        <= '0;
         r_reg        <= '0;
         r_data       <= '0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_busy       <= 1'b0;
         r_fail_index <= '0;
         r_pending    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_delay_cnt  <= w_delay_cnt_nxt;
         r_lut_index  <= w_lut_index_nxt;
         r_retry_cnt  <= w_retry_cnt_nxt;
         r_req        <= w_req_nxt;
         r_dev        <= w_dev_nxt;
         r_reg        <= w_reg_nxt;
         r_data       <= w_data_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
         r_busy       <= w_busy_nxt;
         r_fail_index <= w_fail_index_nxt;
         r_pending    <= w_pending_nxt;
      end
   end

   assign lut_index              = r_lut_index;
   assign busy                   = r_busy;
   assign done                   = r_done;
   assign error                  = r_error;
   assign fail_index             = r_fail_index;
   assign bus.i2c_write_req      = r_req;
   assign bus.i2c_slave_dev_addr = r_dev;
   assign bus.i2c_register_addr  = r_reg;
   assign bus.i2c_data           = r_data;
   assign bus.i2c_addr_2byte     = ADDR_2BYTE;

endmodule

// File: doc/i2c_config_seq.md
# i2c_config_seq

Configuration sequencer that walks the WM8731 register look-up table and turns each entry into one I2C write transaction. It sits between the LUT (which it drives with `lut_index` and reads `lut_data` from) and the I2C write master (which it drives with a req/ack handshake). It applies a power-up delay and retries NACKed writes. It re-runs the whole table on a `start` pulse, for example after a volume change.

## Interface
- `LUT_SIZE`, 10: number of valid LUT entries, indices 0..LUT_SIZE-1.
- `INIT_DELAY`, 50000: clk cycles to wait after reset before the first write.
- `RETRY_MAX`, 3: maximum attempts per entry before declaring failure.
- `ADDR_2BYTE`, 0: value driven on `i2c_addr_2byte`.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request to re-run the table.
- `lut_index` out 10: LUT address.
- `lut_data` in 32: LUT entry `{dev_addr[31:24], reg_addr[23:8], data[7:0]}`, combinational from `lut_index`.
- `i2c_write_req` out 1: write request to the I2C master.
- `i2c_write_req_ack` in 1: one-cycle completion pulse from the master.
- `i2c_error` in 1: NACK flag, valid only in the cycle `i2c_write_req_ack` is high.
- `i2c_slave_dev_addr` out 8: device address.
- `i2c_register_addr` out 16: register address.
- `i2c_data` out 8: write data.
- `i2c_addr_2byte` out 1: tied to `ADDR_2BYTE`.
- `busy` out 1: high while a sequence is in progress.
- `done` out 1: high after all entries were written successfully.
- `error` out 1: high after an entry exhausted its retries.
- `fail_index` out 10: index of the failing entry.

## Operation
- States: WAIT_INIT, CHECK, REQ, WAIT_ACK, GAP, DONE, FAIL.
- Reset values: state WAIT_INIT, all outputs 0, `lut_index` 0, delay and retry counters 0.
- WAIT_INIT: the delay counter counts up. When it reaches `INIT_DELAY-1`, go to CHECK.
- CHECK: evaluate `lut_data` for the current `lut_index`.
  - If `lut_data == 32'hFFFF_FFFF`, or `lut_index >= LUT_SIZE`: go to DONE (early terminator).
  - Otherwise: latch the three fields into the output registers, clear the retry counter, go to REQ.
- REQ: assert `i2c_write_req`, go to WAIT_ACK.
- WAIT_ACK: hold `i2c_write_req` and all `i2c_*` fields stable until `i2c_write_req_ack`.
  - Ack with `i2c_error`=0:
    - Drop req.
    - If `lut_index == LUT_SIZE-1`, go to DONE.
    - Otherwise increment `lut_index` and go to CHECK.
  - Ack with `i2c_error`=1:
    - Drop req and increment the retry counter.
    - If the counter is below `RETRY_MAX`, go to GAP. GAP idles 1 cycle, then returns to REQ with the same fields.
    - Otherwise go to FAIL.
- DONE: `done`=1, `busy`=0.
- FAIL: `error`=1, `fail_index` = `lut_index`, `busy`=0.
- `busy`=1 in every state except DONE and FAIL, including WAIT_INIT.
- `start` in DONE or FAIL:
  - Clears `done`, `error` and `fail_index`.
  - Sets `lut_index` to 0 and goes to CHECK. The init delay is not repeated.
- `start` while busy:
  - Sets a `pending` flag; the running sequence is not disturbed.
  - On entering DONE or FAIL with `pending` set, clear `pending` and restart as above the next cycle.
  - `done`/`error` pulse high for exactly that one cycle.
  - Several starts while busy collapse into one restart.
- Asserting `rst_n` low mid-transaction immediately drops `i2c_write_req` and returns to WAIT_INIT. The full init delay is repeated.

## Timing
- First `i2c_write_req` rises `INIT_DELAY`+2 cycles after reset release.
- Per-entry overhead is 3 cycles (CHECK, REQ, and the ack cycle) plus the master's latency.
- Each retry adds 2 cycles (GAP, REQ).
- `lut_index` changes only in the cycle after a successful ack, or on restart. `lut_data` is therefore valid one cycle later in CHECK.
- `i2c_write_req_ack` outside WAIT_ACK is ignored.
- `done` and `error` are registered and never high together.
- `start` coincident with the final ack sets `pending`, and the table re-runs.

## Structure
- Shared package `wm8731_cfg_pkg`:
  - State enum.
  - LUT field bit positions.
  - Terminator constant `32'hFFFF_FFFF`.
  - `LUT_SIZE` default.
- Single flat module; no sub-module is needed. The init-delay counter is inline.
- At top level it instantiates beside `lut_wm8731` and the I2C master.

## Test plan
- Reset, `INIT_DELAY`=8; model acks every write after 5 cycles, no error.
  - Exactly 10 writes, in index order 0..9.
  - Entry 0 shows dev `8'h34`, reg `16'h0000`, data `8'h97`.
  - Entry 8 carries the volume value.
  - Then `done`=1, `busy`=0.
- Model returns `i2c_error`=1 twice on index 3, then succeeds.
  - Index 3 is issued 3 times with identical fields; at least 1 idle cycle between attempts.
  - Sequence completes with `done`=1.
- Model NACKs index 5 on every attempt, `RETRY_MAX`=3.
  - Exactly 3 attempts; `error`=1, `fail_index`=5.
  - No writes for index 6..9.
- `start` pulses at index 4 and again at index 7.
  - The current pass finishes, then exactly one additional full pass of 10 writes.
  - `done` pulses 1 cycle between passes.
- LUT model returns `32'hFFFF_FFFF` at index 6.
  - Writes only for 0..5, then `done`=1.
- `rst_n` low for 1 cycle while req is held at index 2.
  - req drops asynchronously; init delay restarts; sequence reissues from index 0.
